// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream bundle leaving the FIFO read drain.
// master drives valid/data/last, slave drives ready.
interface fifo_rd_stream_if #(
  parameter int Width = 8
);
  logic             o_valid;
  logic [Width-1:0] o_data;
  logic             o_last;
  logic             i_ready;

  modport master (
    output o_valid,
    output o_data,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain: pops a show-ahead FIFO into a 2-entry skid
// buffer and emits a framed valid/ready stream.
module fifo_rd_stream #(
  parameter int Width       = 8,
  parameter int FrameLen    = 4,
  parameter int StartupHold = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fifo_empty,
  input  logic [Width-1:0] i_fifo_data,
  output logic             o_fifo_rd_en,
  input  logic             i_flush,
  output logic [1:0]       o_count,
  fifo_rd_stream_if.master strm
);

  localparam int BW = (FrameLen > 1) ? $clog2(FrameLen) : 1;
  localparam int HW = $clog2(StartupHold + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(FrameLen - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(StartupHold);

  logic [HW-1:0]    hold_cnt;
  logic             hold_done;
  logic             pace;
  logic [BW-1:0]    beat;
  logic [1:0]       count;
  logic [Width-1:0] ent0;
  logic [Width-1:0] ent1;
  logic             push;
  logic             pop;

  // The empty flag lags a pop, so pace forbids back-to-back pops.
  assign hold_done = (hold_cnt == '0);
  assign push = hold_done & ~i_fifo_empty & ~pace
              & (count != 2'd2) & ~i_flush & ~i_rst;
  assign pop  = (count != 2'd0) & strm.i_ready & ~i_flush;

  assign o_fifo_rd_en = push;
  assign o_count      = count;
  assign strm.o_valid = (count != 2'd0);
  assign strm.o_data  = ent0;
  assign strm.o_last  = (count != 2'd0) & (beat == BEAT_LAST);

  // Startup hold: ignore the FIFO empty flag for a few cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_cnt <= HOLD_INIT;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Pace flag remembers a pop in the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      pace <= 1'b0;
    end else begin
      pace <= push;
    end
  end

  // Beat counter advances on each accepted transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == BEAT_LAST) ? '0 : beat + BW'(1);
    end
  end

  // Skid buffer: ent0 is the head, ent1 the second slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (i_flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            ent0 <= i_fifo_data;
          end else begin
            ent1 <= i_fifo_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          ent0 <= i_fifo_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
